// File: rtl/layer_link.sv
// layer_link: buffers whole parallel layer outputs in a small frame FIFO and
// drains each frame either as a serial stream of elements (MODE 0) or as the
// index of its largest signed element (MODE 1).
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid and ready are both 1. The producer holds its payload and valid stable
// until that edge. o_ready is registered and reflects "FIFO not full";
// i_valid while o_ready=0 discards the frame and flags o_drop/o_overflow.
module layer_link #(
  parameter int N_PARALLEL  = 30,
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_DEPTH = 2,
  parameter int MODE        = 0
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [N_PARALLEL*DATA_WIDTH-1:0] i_data,
  input  logic                             i_valid,
  output logic                             o_ready,
  input  logic                             i_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_valid,
  output logic                             o_last,
  output logic                             o_drop,
  output logic                             o_overflow,
  output logic [1:0]                       o_dbg_state
);

  localparam int FW = N_PARALLEL * DATA_WIDTH;
  localparam int AW = $clog2(FRAME_DEPTH);
  localparam int IW = $clog2(N_PARALLEL);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_PARALLEL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_SCAN = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t state, state_d;

  logic [FW-1:0] mem [FRAME_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d, rd_ptr_inc;
  logic [AW:0]   occupancy;
  logic          empty, full_d, push, pop;
  logic [FW-1:0] head_frame, next_frame;

  logic [IW-1:0]         idx, idx_d, idx_inc;
  logic [DATA_WIDTH-1:0] best_val, best_val_d;
  logic [IW-1:0]         best_idx, best_idx_d;
  logic [DATA_WIDTH-1:0] cur_elem;
  logic                  better;
  logic                  valid_d, last_d;
  logic [DATA_WIDTH-1:0] data_d;

  // Element k of a packed frame.
  function automatic logic [DATA_WIDTH-1:0] elem(input logic [FW-1:0] f,
                                                 input logic [IW-1:0] k);
    return f[int'(k)*DATA_WIDTH +: DATA_WIDTH];
  endfunction

  assign push       = i_valid & o_ready;
  assign occupancy  = wr_ptr - rd_ptr;
  assign empty      = (occupancy == '0);
  assign rd_ptr_inc = rd_ptr + (AW+1)'(1);
  assign head_frame = mem[rd_ptr[AW-1:0]];
  assign next_frame = mem[rd_ptr_inc[AW-1:0]];
  assign wr_ptr_d   = wr_ptr + (AW+1)'(push);
  assign rd_ptr_d   = rd_ptr + (AW+1)'(pop);
  // Same slot index with opposite wrap bits means every slot is occupied.
  assign full_d     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

  assign idx_inc  = idx + IW'(1);
  assign cur_elem = elem(head_frame, idx);
  // Strict greater-than keeps the earliest index on ties.
  assign better   = (idx == '0) || ($signed(cur_elem) > $signed(best_val));

  assign o_dbg_state = state;

  // Frame storage: write-only port, no reset needed on the data itself.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  // FIFO pointers, registered ready and the drop/overflow flags.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_ready    <= 1'b0;
      o_drop     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      o_ready    <= ~full_d;
      o_drop     <= i_valid & ~o_ready;
      o_overflow <= o_overflow | (i_valid & ~o_ready);
    end
  end

  // FSM state, element index, scan accumulator and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state    <= S_IDLE;
      idx      <= '0;
      best_val <= '0;
      best_idx <= '0;
      o_valid  <= 1'b0;
      o_last   <= 1'b0;
      o_data   <= '0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      best_val <= best_val_d;
      best_idx <= best_idx_d;
      o_valid  <= valid_d;
      o_last   <= last_d;
      o_data   <= data_d;
    end
  end

  // Next-state and next-output logic for both drain modes.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    best_val_d = best_val;
    best_idx_d = best_idx;
    valid_d    = o_valid;
    last_d     = o_last;
    data_d     = o_data;
    pop        = 1'b0;

    case (state)
      S_IDLE: begin
        if (MODE == 0) begin
          // Bypass the incoming frame when the FIFO is empty so element 0
          // appears on the cycle right after the write.
          if (!empty) begin
            state_d = S_SEND;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            data_d  = elem(head_frame, '0);
          end else if (push) begin
            state_d = S_SEND;
            idx_d   = '0;
            valid_d = 1'b1;
            last_d  = 1'b0;
            data_d  = elem(i_data, '0);
          end
        end else begin
          // The frame lands in memory on this edge, so scanning can read it.
          if (!empty || push) begin
            state_d = S_SCAN;
            idx_d   = '0;
          end
        end
      end

      S_SEND: begin
        if (i_ready) begin
          if (idx == LAST_IDX) begin
            pop   = 1'b1;
            idx_d = '0;
            if (occupancy > (AW+1)'(1)) begin
              data_d = elem(next_frame, '0);
              last_d = 1'b0;
            end else if (push) begin
              data_d = elem(i_data, '0);
              last_d = 1'b0;
            end else begin
              valid_d = 1'b0;
              last_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            idx_d  = idx_inc;
            data_d = elem(head_frame, idx_inc);
            last_d = (idx_inc == LAST_IDX);
          end
        end
      end

      S_SCAN: begin
        if (better) begin
          best_val_d = cur_elem;
          best_idx_d = idx;
        end
        if (idx == LAST_IDX) begin
          state_d = S_HOLD;
          idx_d   = '0;
          valid_d = 1'b1;
          last_d  = 1'b1;
          data_d  = DATA_WIDTH'(better ? idx : best_idx);
        end else begin
          idx_d = idx_inc;
        end
      end

      S_HOLD: begin
        if (i_ready) begin
          pop     = 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_layer_link.sv
// Directed bench for layer_link: one serializing instance (MODE 0) and one
// argmax instance (MODE 1) share the stimulus; each scenario checks one of them.
module tb_layer_link;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N*W-1:0] data;
  logic           valid;
  logic           ready;

  logic         m0_ready, m0_valid, m0_last, m0_drop, m0_ovf;
  logic [W-1:0] m0_data;
  logic [1:0]   m0_state;
  logic         m1_ready, m1_valid, m1_last, m1_drop, m1_ovf;
  logic [W-1:0] m1_data;
  logic [1:0]   m1_state;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  // Clock and reset block
  always #5 clk = ~clk;

  layer_link #(.N_PARALLEL(N), .DATA_WIDTH(W), .FRAME_DEPTH(D), .MODE(0)) dut0 (
    .i_clk(clk), .i_reset(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(m0_ready), .i_ready(ready), .o_data(m0_data), .o_valid(m0_valid),
    .o_last(m0_last), .o_drop(m0_drop), .o_overflow(m0_ovf), .o_dbg_state(m0_state)
  );

  layer_link #(.N_PARALLEL(N), .DATA_WIDTH(W), .FRAME_DEPTH(D), .MODE(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_data(data), .i_valid(valid),
    .o_ready(m1_ready), .i_ready(ready), .o_data(m1_data), .o_valid(m1_valid),
    .o_last(m1_last), .o_drop(m1_drop), .o_overflow(m1_ovf), .o_dbg_state(m1_state)
  );

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    data  = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    data  = '0;
    step();
    step();
    vectors++;
    if ({m0_valid, m0_last, m0_drop, m0_ovf, m0_ready} !== 5'b0 || m0_data !== 8'h00 ||
        m0_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_m0: got v=%b l=%b d=%b o=%b r=%b data=%h st=%0d, want all 0",
               m0_valid, m0_last, m0_drop, m0_ovf, m0_ready, m0_data, m0_state);
    end
    vectors++;
    if ({m1_valid, m1_last, m1_drop, m1_ovf, m1_ready} !== 5'b0 || m1_data !== 8'h00 ||
        m1_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_m1: got v=%b l=%b d=%b o=%b r=%b data=%h st=%0d, want all 0",
               m1_valid, m1_last, m1_drop, m1_ovf, m1_ready, m1_data, m1_state);
    end
    rst_n = 1'b1;
    #1;
    vectors++;
    if (m0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_before_edge: got %b, want 0", m0_ready);
    end
    step();
    vectors++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_after_release: got m0=%b m1=%b, want 1 1", m0_ready, m1_ready);
    end
  endtask

  task automatic test_serialize();
    do_reset();
    ready = 1'b1;
    data  = 32'h0403_0201;
    valid = 1'b1;
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    step();
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (m0_valid !== 1'b1 || m0_data !== e || m0_last !== (i == N-1)) begin
        miscompares++;
        $display("FAIL serialize_beat%0d: got v=%b data=%h last=%b, want v=1 data=%h last=%b",
                 i, m0_valid, m0_data, m0_last, e, (i == N-1));
      end
      step();
    end
    vectors++;
    if (m0_valid !== 1'b0 || m0_last !== 1'b0 || m0_data !== 8'h04) begin
      miscompares++;
      $display("FAIL serialize_idle: got v=%b last=%b data=%h, want v=0 last=0 data=04",
               m0_valid, m0_last, m0_data);
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready = 1'b1;
    data  = 32'h0403_0201;
    valid = 1'b1;
    step();
    valid = 1'b0;
    vectors++;
    if (m0_valid !== 1'b1 || m0_data !== 8'h01) begin
      miscompares++;
      $display("FAIL stall_first: got v=%b data=%h, want v=1 data=01", m0_valid, m0_data);
    end
    step();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (m0_valid !== 1'b1 || m0_data !== 8'h02 || m0_last !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got v=%b data=%h last=%b, want v=1 data=02 last=0",
                 i, m0_valid, m0_data, m0_last);
      end
      if (i < 3) step();
    end
    ready = 1'b1;
    step();
    vectors++;
    if (m0_valid !== 1'b1 || m0_data !== 8'h03 || m0_last !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_resume: got v=%b data=%h last=%b, want v=1 data=03 last=0",
               m0_valid, m0_data, m0_last);
    end
    step();
    vectors++;
    if (m0_valid !== 1'b1 || m0_data !== 8'h04 || m0_last !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_last: got v=%b data=%h last=%b, want v=1 data=04 last=1",
               m0_valid, m0_data, m0_last);
    end
    step();
    vectors++;
    if (m0_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_end: got v=%b, want 0", m0_valid);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ready = 1'b0;
    valid = 1'b1;
    data  = 32'h0D0C_0B0A;
    step();
    vectors++;
    if (m0_ready !== 1'b1 || m0_valid !== 1'b1 || m0_data !== 8'h0A) begin
      miscompares++;
      $display("FAIL b2b_first: got r=%b v=%b data=%h, want r=1 v=1 data=0a",
               m0_ready, m0_valid, m0_data);
    end
    data = 32'h1D1C_1B1A;
    step();
    vectors++;
    if (m0_ready !== 1'b0 || m0_drop !== 1'b0 || m0_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full: got r=%b drop=%b ovf=%b, want r=0 drop=0 ovf=0",
               m0_ready, m0_drop, m0_ovf);
    end
    data = 32'h2D2C_2B2A;
    step();
    valid = 1'b0;
    vectors++;
    if (m0_drop !== 1'b1 || m0_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_drop: got drop=%b ovf=%b, want 1 1", m0_drop, m0_ovf);
    end
    step();
    vectors++;
    if (m0_drop !== 1'b0 || m0_ovf !== 1'b1 || m0_data !== 8'h0A || m0_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_sticky: got drop=%b ovf=%b data=%h r=%b, want 0 1 0a 0",
               m0_drop, m0_ovf, m0_data, m0_ready);
    end
    exp_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h1A, 8'h1B, 8'h1C, 8'h1D};
    ready = 1'b1;
    for (int i = 0; i < 2*N; i++) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      vectors++;
      if (m0_valid !== 1'b1 || m0_data !== e || m0_last !== (i % N == N-1) ||
          m0_ready !== (i >= N)) begin
        miscompares++;
        $display("FAIL b2b_beat%0d: got v=%b data=%h last=%b r=%b, want v=1 data=%h last=%b r=%b",
                 i, m0_valid, m0_data, m0_last, m0_ready, e, (i % N == N-1), (i >= N));
      end
      step();
    end
    vectors++;
    if (m0_valid !== 1'b0 || m0_ovf !== 1'b1 || m0_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_drained: got v=%b ovf=%b r=%b, want 0 1 1", m0_valid, m0_ovf, m0_ready);
    end
  endtask

  task automatic test_argmax();
    logic [N*W-1:0] frames [4];
    logic [W-1:0]   winner [4];
    frames[0] = 32'h0510_F010;  winner[0] = 8'h00;
    frames[1] = 32'h7F7F_FF80;  winner[1] = 8'h02;
    frames[2] = 32'h8080_8080;  winner[2] = 8'h00;
    frames[3] = 32'h7FFE_0180;  winner[3] = 8'h03;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      ready = (f != 0);
      data  = frames[f];
      valid = 1'b1;
      step();
      valid = 1'b0;
      for (int c = 0; c < N; c++) begin
        vectors++;
        if (m1_valid !== 1'b0 || m1_last !== 1'b0) begin
          miscompares++;
          $display("FAIL argmax%0d_early%0d: got v=%b last=%b, want 0 0", f, c, m1_valid, m1_last);
        end
        step();
      end
      vectors++;
      if (m1_valid !== 1'b1 || m1_last !== 1'b1 || m1_data !== winner[f]) begin
        miscompares++;
        $display("FAIL argmax%0d_result: got v=%b last=%b data=%h, want v=1 last=1 data=%h",
                 f, m1_valid, m1_last, m1_data, winner[f]);
      end
      if (f == 0) begin
        step();
        step();
        vectors++;
        if (m1_valid !== 1'b1 || m1_last !== 1'b1 || m1_data !== winner[f]) begin
          miscompares++;
          $display("FAIL argmax_hold: got v=%b last=%b data=%h, want v=1 last=1 data=%h",
                   m1_valid, m1_last, m1_data, winner[f]);
        end
        ready = 1'b1;
      end
      step();
      vectors++;
      if (m1_valid !== 1'b0 || m1_last !== 1'b0 || m1_data !== winner[f]) begin
        miscompares++;
        $display("FAIL argmax%0d_after: got v=%b last=%b data=%h, want v=0 last=0 data=%h",
                 f, m1_valid, m1_last, m1_data, winner[f]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    ready = 1'b1;
    data  = 32'h1413_1211;
    valid = 1'b1;
    step();
    vectors++;
    if (m0_data !== 8'h11) begin
      miscompares++;
      $display("FAIL midrst_e0: got %h, want 11", m0_data);
    end
    data = 32'h2423_2221;
    step();
    valid = 1'b0;
    vectors++;
    if (m0_data !== 8'h12) begin
      miscompares++;
      $display("FAIL midrst_e1: got %h, want 12", m0_data);
    end
    step();
    vectors++;
    if (m0_data !== 8'h13 || m0_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_e2: got v=%b data=%h, want v=1 data=13", m0_valid, m0_data);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (m0_valid !== 1'b0 || m0_last !== 1'b0 || m0_data !== 8'h00 || m0_ready !== 1'b0 ||
        m0_state !== 2'd0) begin
      miscompares++;
      $display("FAIL midrst_async: got v=%b l=%b data=%h r=%b st=%0d, want 0 0 00 0 0",
               m0_valid, m0_last, m0_data, m0_ready, m0_state);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    vectors++;
    if (m0_ready !== 1'b1 || m0_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_release: got r=%b ovf=%b, want 1 0", m0_ready, m0_ovf);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (m0_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_quiet%0d: got v=%b, want 0", i, m0_valid);
      end
    end
  endtask

  // Sequence the scenarios and print the report
  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    ready = 1'b0;
    data  = '0;
    test_reset();
    test_serialize();
    test_stall();
    test_back_to_back();
    test_argmax();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
